// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops an async FIFO read port and re-emits the words as a
// valid/ready stream with a fixed-length burst marker, via a 3-entry skid buffer.
module fifo_stream_reader #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic             clk_read,
    input  logic             r_resetn,
    input  logic             rd_enable,
    input  logic             fifo_empty,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_rd_en,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy
);
    localparam int CW = $clog2(BURST_LEN + 1);

    logic [WIDTH-1:0] mem [3];
    logic [1:0]       occ;
    logic             inflight;
    logic [CW-1:0]    beat_cnt;
    logic             pop;
    logic [1:0]       wr_idx;

    // Reserve a slot for every word in flight so the buffer can never overflow.
    assign fifo_rd_en = r_resetn & rd_enable & !fifo_empty & (({1'b0, occ} + {2'b00, inflight}) < 3'd3);
    assign m_valid    = occ != 2'd0;
    assign m_data     = mem[0];
    assign m_last     = m_valid & (beat_cnt == CW'(BURST_LEN - 1));
    assign busy       = m_valid | inflight;
    assign pop        = m_valid & m_ready;
    assign wr_idx     = occ - {1'b0, pop};

    always_ff @(posedge clk_read or negedge r_resetn) begin
        if (!r_resetn) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            beat_cnt <= '0;
        end else begin
            inflight <= fifo_rd_en;
            occ      <= occ + {1'b0, inflight} - {1'b0, pop};
            if (pop)
                beat_cnt <= m_last ? '0 : beat_cnt + 1'b1;
        end
    end

    // Head shifts forward on pop; a capture lands just behind the surviving entries.
    always_ff @(posedge clk_read) begin
        if (pop) begin
            mem[0] <= mem[1];
            mem[1] <= mem[2];
        end
        if (inflight)
            mem[wr_idx] <= fifo_data;
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: queue-based reference model of the reader, one compare
// process per cycle, directed scenarios plus a randomized 1000-word run.
module tb_fifo_stream_reader;
    logic       clk_read = 1'b0;
    logic       r_resetn = 1'b0;
    logic       rd_enable = 1'b1;
    logic       fifo_empty = 1'b1;
    logic       m_ready = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       rd4, v4, l4, b4, rd1, v1, l1, b1, rd5, v5, l5, b5;
    logic [7:0] d4, d1, d5;

    always #5 clk_read = ~clk_read;

    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(4)) dut4 (.clk_read(clk_read), .r_resetn(r_resetn), .rd_enable(rd_enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(rd4), .m_valid(v4), .m_ready(m_ready), .m_data(d4), .m_last(l4), .busy(b4));
    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(1)) dut1 (.clk_read(clk_read), .r_resetn(r_resetn), .rd_enable(rd_enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(rd1), .m_valid(v1), .m_ready(m_ready), .m_data(d1), .m_last(l1), .busy(b1));
    fifo_stream_reader #(.WIDTH(8), .BURST_LEN(5)) dut5 (.clk_read(clk_read), .r_resetn(r_resetn), .rd_enable(rd_enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(rd5), .m_valid(v5), .m_ready(m_ready), .m_data(d5), .m_last(l5), .busy(b5));

    logic [7:0] q[$], sent[$], mb[$], got[$];
    bit         got_last[$];
    bit         infl_m, ev, erd, hs;
    int         beats, pops, cyc, n_chk, n_fail;
    int         pop_cyc = -1, val_cyc = -1, first_hs = -1, last_hs = -1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Model: mb is the buffer contents, infl_m the pop issued last edge, beats the handshakes since reset.
    always @(negedge clk_read) begin
        cyc++;
        if (!r_resetn) begin
            mb.delete();
            infl_m = 1'b0;
            beats = 0;
        end else begin
            ev  = mb.size() != 0;
            erd = rd_enable && !fifo_empty && (mb.size() + int'(infl_m) < 3);
            chk("fifo_rd_en_b4", rd4, erd);
            chk("fifo_rd_en_b1", rd1, erd);
            chk("fifo_rd_en_b5", rd5, erd);
            chk("m_valid_b4", v4, ev);
            chk("m_valid_b1", v1, ev);
            chk("m_valid_b5", v5, ev);
            chk("busy_b4", b4, ev | infl_m);
            chk("busy_b1", b1, ev | infl_m);
            chk("busy_b5", b5, ev | infl_m);
            chk("m_last_b4", l4, ev && (beats % 4 == 3));
            chk("m_last_b1", l1, ev);
            chk("m_last_b5", l5, ev && (beats % 5 == 4));
            if (ev) begin
                chk("m_data_b4", d4, mb[0]);
                chk("m_data_b1", d1, mb[0]);
                chk("m_data_b5", d5, mb[0]);
            end
            if (rd4 && pop_cyc < 0) pop_cyc = cyc;
            if (v4 && val_cyc < 0) val_cyc = cyc;
            hs = ev && m_ready;
            if (hs) begin
                got.push_back(mb[0]);
                got_last.push_back(l4);
                void'(mb.pop_front());
                beats++;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
            end
            if (infl_m) mb.push_back(fifo_data);
            chk("occ_le_3", mb.size() <= 3, 1);
            infl_m = rd4;
            pops += int'(rd4);
        end
    end

    task automatic step(input bit rdy, input bit ren);
        @(posedge clk_read);
        #1;
        if (infl_m && q.size() != 0) fifo_data = q.pop_front();
        m_ready = rdy;
        rd_enable = ren;
        fifo_empty = q.size() == 0;
    endtask

    task automatic push(input logic [7:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_log();
        got.delete();
        got_last.delete();
        pops = 0;
        pop_cyc = -1;
        val_cyc = -1;
        first_hs = -1;
        last_hs = -1;
    endtask

    task automatic do_reset();
        @(posedge clk_read);
        #1;
        r_resetn = 1'b0;
        q.delete();
        fifo_empty = 1'b1;
        repeat (2) @(posedge clk_read);
        #1;
        r_resetn = 1'b1;
        rd_enable = 1'b1;
        m_ready = 1'b1;
        clear_log();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w, held;
        bit found;
        repeat (3) @(posedge clk_read);
        #1;
        chk("rst_rd_en", {rd4, rd1, rd5}, 0);
        chk("rst_valid", {v4, v1, v5}, 0);
        chk("rst_last", {l4, l1, l5}, 0);
        chk("rst_busy", {b4, b1, b5}, 0);
        r_resetn = 1'b1;

        push(8'hA5);
        repeat (6) step(1, 1);
        @(negedge clk_read);
        #1;
        chk("single_latency", val_cyc - pop_cyc, 2);
        chk("single_pops", pops, 1);
        chk("single_count", got.size(), 1);
        if (got.size() > 0) begin
            chk("single_data", got[0], 8'hA5);
            chk("single_last", got_last[0], 0);
        end

        do_reset();
        for (int i = 0; i < 16; i++) push(8'(i));
        repeat (25) step(1, 1);
        @(negedge clk_read);
        #1;
        chk("stream_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            chk("stream_data", got[i], i);
            chk("stream_last", got_last[i], (i % 4) == 3);
        end
        chk("stream_rate", last_hs - first_hs, 15);

        do_reset();
        for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
        repeat (4) step(1, 1);
        held = 8'h00;
        for (int k = 0; k < 10; k++) begin
            step(0, 1);
            @(negedge clk_read);
            #1;
            chk("stall_valid", v4, 1);
            if (k == 0) held = d4;
            else chk("stall_data_stable", d4, held);
        end
        chk("stall_rd_en", rd4, 0);
        chk("stall_buffered", pops - got.size(), 3);
        repeat (25) step(1, 1);
        @(negedge clk_read);
        #1;
        chk("stall_count", got.size(), 16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("stall_order", got[i], 8'h20 + 8'(i));

        do_reset();
        push(8'h51);
        push(8'h52);
        push(8'h53);
        found = 1'b0;
        for (int k = 0; k < 5 && !found; k++) begin
            @(negedge clk_read);
            #1;
            found = rd4;
        end
        chk("rden_pop_seen", found, 1);
        step(1, 0);
        repeat (8) step(1, 0);
        @(negedge clk_read);
        #1;
        chk("rden_pops", pops, 1);
        chk("rden_count", got.size(), 1);
        if (got.size() > 0) chk("rden_data", got[0], 8'h51);
        chk("rden_busy", b4, 0);
        chk("rden_rd_en", rd4, 0);

        // Stop at occ=2 with a word still in flight, then reset between clock edges.
        do_reset();
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i));
        m_ready = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step(0, 1);
            @(negedge clk_read);
            #1;
            found = v4 && !rd4 && b4;
        end
        chk("midrst_reached", found, 1);
        r_resetn = 1'b0;
        #1;
        chk("midrst_rd_en", {rd4, rd1, rd5}, 0);
        chk("midrst_valid", {v4, v1, v5}, 0);
        chk("midrst_last", {l4, l1, l5}, 0);
        chk("midrst_busy", {b4, b1, b5}, 0);
        q.delete();
        fifo_empty = 1'b1;
        repeat (2) @(posedge clk_read);
        #1;
        r_resetn = 1'b1;
        clear_log();

        do_reset();
        sent.delete();
        for (int c = 0; c < 20000 && got.size() < 1000; c++) begin
            step($urandom_range(0, 9) < 6, 1);
            if (sent.size() < 1000 && $urandom_range(0, 9) < 7) begin
                w = 8'($urandom);
                push(w);
                sent.push_back(w);
            end
        end
        chk("rand_count", got.size(), 1000);
        for (int i = 0; i < got.size() && i < sent.size(); i++) chk("rand_order", got[i], sent[i]);
        repeat (4) step(1, 1);
        @(negedge clk_read);
        #1;
        chk("rand_drain_busy", {b4, b1, b5}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
